// File: rtl/pkt_fifo_sf_avlstrm_pkg.sv
// Shared types for the store-and-forward packet FIFO: ingress FSM states,
// RAM entry layout and the saturating statistics increment.
package pkt_fifo_sf_avlstrm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } ing_state_t;

    // Entry layout of the default build; RAM words use this field order for any beat width.
    localparam int ENTRY_DW = 512;
    localparam int ENTRY_EW = 6;

    typedef struct packed {
        logic                sop;
        logic                eop;
        logic [ENTRY_EW-1:0] empty;
        logic [ENTRY_DW-1:0] data;
    } entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc);
        return (inc && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/pkt_fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port with a registered,
// enable-held read output.
module pkt_fifo_sdp_ram
    import pkt_fifo_sf_avlstrm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rd_data holds its value when rd_en is low, so it doubles as the egress register.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pkt_fifo_sf_avlstrm.sv
// Store-and-forward Avalon-ST packet FIFO. Define PKT_FIFO_STATS_EN to build the
// pkt/drop/err statistics counters; otherwise those ports read as zero.
module pkt_fifo_sf_avlstrm
    import pkt_fifo_sf_avlstrm_pkg::*;
#(
    parameter int SYMBOLS_PER_BEAT = 64,
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int FIFO_DEPTH       = 512,
    parameter int FULL_LEVEL       = 450,
    localparam int DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL,
    localparam int EW = $clog2(SYMBOLS_PER_BEAT)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic [EW-1:0] in_empty,
    output logic          in_ready,
    output logic          in_almost_full,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic [EW-1:0] out_empty,
    input  logic          out_ready,
    output logic [31:0]   fill_level,
    output logic [31:0]   pkt_count,
    output logic [31:0]   drop_count,
    output logic [31:0]   err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = DW + EW + 2;

    typedef logic [AW:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(FIFO_DEPTH);
    localparam ptr_t FULL_P  = ptr_t'(FULL_LEVEL);
    localparam ptr_t ONE_P   = ptr_t'(1);

    ing_state_t state, state_nxt;
    ptr_t       wr_ptr, cm_ptr, rd_ptr;
    ptr_t       wr_nxt, cm_nxt, wr_base, fetch_ptr, fill;
    logic       beat, restart, we, pkt_inc, drop_inc, err_inc;
    logic       take, ram_ren, valid_q;
    logic [RW-1:0] ram_q;

    assign beat = in_valid & in_ready;
    assign take = valid_q & out_ready;

    // A sop beat arriving in any state restarts from the committed pointer; wr_base
    // is where that new packet (or the continuing one) lands.
    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_ptr;
        cm_nxt    = cm_ptr;
        wr_base   = wr_ptr;
        restart   = 1'b0;
        we        = 1'b0;
        pkt_inc   = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        if (beat) begin
            case (state)
                ST_IDLE: begin
                    if (in_sop) restart = 1'b1;
                    else        err_inc = 1'b1;
                end
                ST_WRITE: begin
                    if (in_sop) begin
                        wr_base = cm_ptr;
                        err_inc = 1'b1;
                        restart = 1'b1;
                    end else if (ptr_t'(wr_ptr - rd_ptr) == DEPTH_P) begin
                        wr_nxt    = cm_ptr;
                        drop_inc  = 1'b1;
                        state_nxt = in_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        we     = 1'b1;
                        wr_nxt = wr_ptr + ONE_P;
                        if (in_eop) begin
                            cm_nxt    = wr_ptr + ONE_P;
                            pkt_inc   = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (in_sop) begin
                        err_inc = 1'b1;
                        restart = 1'b1;
                    end else if (in_eop) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
            if (restart) begin
                if (ptr_t'(wr_base - rd_ptr) == DEPTH_P) begin
                    wr_nxt    = wr_base;
                    drop_inc  = 1'b1;
                    state_nxt = in_eop ? ST_IDLE : ST_DROP;
                end else begin
                    we     = 1'b1;
                    wr_nxt = wr_base + ONE_P;
                    if (in_eop) begin
                        cm_nxt    = wr_base + ONE_P;
                        pkt_inc   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
        end
    end

    // rd_ptr advances on egress transfer; the prefetched beat sits one entry ahead.
    assign fetch_ptr = rd_ptr + ptr_t'(valid_q);
    assign ram_ren   = (cm_ptr != fetch_ptr) && (!valid_q || out_ready);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            rd_ptr   <= '0;
            valid_q  <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_nxt;
            cm_ptr   <= cm_nxt;
            in_ready <= 1'b1;
            if (take)         rd_ptr  <= rd_ptr + ONE_P;
            if (ram_ren)      valid_q <= 1'b1;
            else if (take)    valid_q <= 1'b0;
        end
    end

    pkt_fifo_sdp_ram #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk     (Clk),
        .wr_en   (we),
        .wr_addr (wr_base[AW-1:0]),
        .wr_data ({in_sop, in_eop, in_empty, in_data}),
        .rd_en   (ram_ren),
        .rd_addr (fetch_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    // RAM read data is not reset, so egress fields are masked until a beat is valid.
    assign {out_sop, out_eop, out_empty, out_data} = valid_q ? ram_q : '0;
    assign out_valid      = valid_q;
    assign fill           = cm_ptr - rd_ptr;
    assign fill_level     = 32'(fill);
    assign in_almost_full = (fill >= FULL_P);

`ifdef PKT_FIFO_STATS_EN
    logic [31:0] pkt_q, drop_q, err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pkt_q  <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            pkt_q  <= sat_inc(pkt_q, pkt_inc);
            drop_q <= sat_inc(drop_q, drop_inc);
            err_q  <= sat_inc(err_q, err_inc);
        end
    end

    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
    assign err_count  = err_q;
`else
    logic unused_stats;
    assign unused_stats = ^{pkt_inc, drop_inc, err_inc};
    assign pkt_count    = '0;
    assign drop_count   = '0;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_pkt_fifo_sf_avlstrm.sv
// Bench for pkt_fifo_sf_avlstrm: a depth-8 instance for directed cases and a
// depth-512 instance for the randomised stream, each with an egress scoreboard.
`timescale 1ns/1ps
module tb_pkt_fifo_sf_avlstrm;

    localparam int DW = 32;
    localparam int EW = 2;
`ifdef PKT_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic [DW-1:0] s_in_data = '0, l_in_data = '0;
    logic          s_in_valid = 1'b0, s_in_sop = 1'b0, s_in_eop = 1'b0;
    logic          l_in_valid = 1'b0, l_in_sop = 1'b0, l_in_eop = 1'b0;
    logic [EW-1:0] s_in_empty = '0, l_in_empty = '0;
    logic          s_out_ready = 1'b0, l_out_ready = 1'b0;
    logic          s_in_ready, s_in_almost_full, s_out_valid, s_out_sop, s_out_eop;
    logic          l_in_ready, l_in_almost_full, l_out_valid, l_out_sop, l_out_eop;
    logic [DW-1:0] s_out_data, l_out_data;
    logic [EW-1:0] s_out_empty, l_out_empty;
    logic [31:0]   s_fill_level, s_pkt_count, s_drop_count, s_err_count;
    logic [31:0]   l_fill_level, l_pkt_count, l_drop_count, l_err_count;

    pkt_fifo_sf_avlstrm #(
        .SYMBOLS_PER_BEAT(4), .BITS_PER_SYMBOL(8), .FIFO_DEPTH(8), .FULL_LEVEL(6)
    ) dut_s (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_sop(s_in_sop), .in_eop(s_in_eop),
        .in_empty(s_in_empty), .in_ready(s_in_ready), .in_almost_full(s_in_almost_full),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_sop(s_out_sop), .out_eop(s_out_eop),
        .out_empty(s_out_empty), .out_ready(s_out_ready), .fill_level(s_fill_level),
        .pkt_count(s_pkt_count), .drop_count(s_drop_count), .err_count(s_err_count)
    );

    pkt_fifo_sf_avlstrm #(
        .SYMBOLS_PER_BEAT(4), .BITS_PER_SYMBOL(8), .FIFO_DEPTH(512), .FULL_LEVEL(450)
    ) dut_l (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(l_in_data), .in_valid(l_in_valid), .in_sop(l_in_sop), .in_eop(l_in_eop),
        .in_empty(l_in_empty), .in_ready(l_in_ready), .in_almost_full(l_in_almost_full),
        .out_data(l_out_data), .out_valid(l_out_valid), .out_sop(l_out_sop), .out_eop(l_out_eop),
        .out_empty(l_out_empty), .out_ready(l_out_ready), .fill_level(l_fill_level),
        .pkt_count(l_pkt_count), .drop_count(l_drop_count), .err_count(l_err_count)
    );

    beat_t s_exp[$];
    beat_t l_exp[$];
    beat_t s_got, s_want, l_got, l_want, l_prev;
    logic  l_prev_stall = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    s_pkt = 0, s_drop = 0, s_err = 0;

    // Egress scoreboards: every transferred beat must match the oldest expected beat.
    always @(negedge Clk) begin
        if (Rst_n && s_out_valid && s_out_ready) begin
            s_got = {s_out_sop, s_out_eop, s_out_empty, s_out_data};
            n_checks++;
            if (s_exp.size() == 0) begin
                n_fail++;
                $display("FAIL s_egress_unexpected: got %h, expected no beat", s_got);
            end else begin
                s_want = s_exp.pop_front();
                if (s_got !== s_want) begin
                    n_fail++;
                    $display("FAIL s_egress_beat: got %h, expected %h", s_got, s_want);
                end
            end
        end
    end

    always @(negedge Clk) begin
        l_got = {l_out_sop, l_out_eop, l_out_empty, l_out_data};
        if (l_prev_stall) begin
            n_checks++;
            if (!l_out_valid || l_got !== l_prev) begin
                n_fail++;
                $display("FAIL l_stall_hold: got valid=%b %h, expected valid=1 %h", l_out_valid, l_got, l_prev);
            end
        end
        if (Rst_n && l_out_valid && l_out_ready) begin
            n_checks++;
            if (l_exp.size() == 0) begin
                n_fail++;
                $display("FAIL l_egress_unexpected: got %h, expected no beat", l_got);
            end else begin
                l_want = l_exp.pop_front();
                if (l_got !== l_want) begin
                    n_fail++;
                    $display("FAIL l_egress_beat: got %h, expected %h", l_got, l_want);
                end
            end
        end
        l_prev_stall = Rst_n && l_out_valid && !l_out_ready;
        l_prev       = l_got;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic beat_t mk(input logic sop, input logic eop, input logic [EW-1:0] e,
                                 input logic [DW-1:0] d);
        beat_t b;
        b.sop = sop; b.eop = eop; b.empty = e; b.data = d;
        return b;
    endfunction

    task automatic s_beat(input beat_t b);
        s_in_data = b.data; s_in_sop = b.sop; s_in_eop = b.eop; s_in_empty = b.empty;
        s_in_valid = 1'b1;
        @(posedge Clk); #1;
        s_in_valid = 1'b0;
    endtask

    task automatic l_beat(input beat_t b);
        l_in_data = b.data; l_in_sop = b.sop; l_in_eop = b.eop; l_in_empty = b.empty;
        l_in_valid = 1'b1;
        @(posedge Clk); #1;
        l_in_valid = 1'b0;
    endtask

    task automatic s_packet(input int len, input bit keep);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk(i == 0, i == len - 1, EW'($urandom), $urandom);
            if (keep) s_exp.push_back(b);
            s_beat(b);
        end
    endtask

    task automatic s_drain(input int limit);
        for (int i = 0; i < limit && s_exp.size() != 0; i++) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (s_in_ready !== 1'b0 || l_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b/%b, expected 0/0", s_in_ready, l_in_ready);
        end
        n_checks++;
        if (s_out_valid !== 1'b0 || s_fill_level !== 32'd0 || s_in_almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b fill=%0d af=%b, expected 0 0 0", s_out_valid, s_fill_level, s_in_almost_full);
        end
        n_checks++;
        if ({s_pkt_count, s_drop_count, s_err_count} !== 96'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", s_pkt_count, s_drop_count, s_err_count);
        end
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk); #1;
        n_checks++;
        if (s_in_ready !== 1'b1 || l_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_in_ready: got %b/%b, expected 1/1", s_in_ready, l_in_ready);
        end
    endtask

    task automatic test_basic;
        beat_t b[4];
        s_out_ready = 1'b1;
        b[0] = mk(1'b1, 1'b0, 2'd0, 32'hA000_0001);
        b[1] = mk(1'b0, 1'b0, 2'd0, 32'hA000_0002);
        b[2] = mk(1'b0, 1'b0, 2'd0, 32'hA000_0003);
        b[3] = mk(1'b0, 1'b1, 2'd2, 32'hA000_0004);
        for (int i = 0; i < 4; i++) s_exp.push_back(b[i]);
        for (int i = 0; i < 4; i++) begin
            s_beat(b[i]);
            if (i < 3) begin
                n_checks++;
                if (s_out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL basic_no_early_egress: got %b at beat %0d, expected 0", s_out_valid, i);
                end
            end
        end
        s_pkt++;
        n_checks++;
        if (s_out_valid !== 1'b0 || s_fill_level !== 32'd4) begin
            n_fail++; $display("FAIL basic_commit_cycle: got valid=%b fill=%0d, expected 0 4", s_out_valid, s_fill_level);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (s_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_latency: got out_valid=%b, expected 1", s_out_valid);
        end
        s_drain(50);
        n_checks++;
        if (s_exp.size() != 0 || s_fill_level !== 32'd0) begin
            n_fail++; $display("FAIL basic_drain: got left=%0d fill=%0d, expected 0 0", s_exp.size(), s_fill_level);
        end
        n_checks++;
        if (s_pkt_count !== (STATS ? 32'(s_pkt) : 32'd0)) begin
            n_fail++; $display("FAIL basic_pkt_count: got %0d, expected %0d", s_pkt_count, STATS ? s_pkt : 0);
        end
    endtask

    task automatic test_overflow;
        s_out_ready = 1'b0;
        s_packet(10, 1'b0);
        s_drop++;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (s_fill_level !== 32'd0 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL overflow_discard: got fill=%0d valid=%b, expected 0 0", s_fill_level, s_out_valid);
        end
        n_checks++;
        if (s_drop_count !== (STATS ? 32'(s_drop) : 32'd0)) begin
            n_fail++; $display("FAIL overflow_drop_count: got %0d, expected %0d", s_drop_count, STATS ? s_drop : 0);
        end
        s_packet(3, 1'b1);
        s_pkt++;
        n_checks++;
        if (s_fill_level !== 32'd3) begin
            n_fail++; $display("FAIL overflow_next_fill: got %0d, expected 3", s_fill_level);
        end
        s_out_ready = 1'b1;
        s_drain(50);
        n_checks++;
        if (s_exp.size() != 0 || s_fill_level !== 32'd0) begin
            n_fail++; $display("FAIL overflow_next_drain: got left=%0d fill=%0d, expected 0 0", s_exp.size(), s_fill_level);
        end
    endtask

    task automatic test_errors;
        beat_t b[3];
        s_out_ready = 1'b1;
        s_beat(mk(1'b0, 1'b0, 2'd0, 32'hE000_0001));
        s_beat(mk(1'b0, 1'b1, 2'd1, 32'hE000_0002));
        s_err += 2;
        s_beat(mk(1'b1, 1'b0, 2'd0, 32'hBAD0_0001));
        s_beat(mk(1'b0, 1'b0, 2'd0, 32'hBAD0_0002));
        b[0] = mk(1'b1, 1'b0, 2'd0, 32'hB000_0001);
        b[1] = mk(1'b0, 1'b0, 2'd0, 32'hB000_0002);
        b[2] = mk(1'b0, 1'b1, 2'd3, 32'hB000_0003);
        for (int i = 0; i < 3; i++) s_exp.push_back(b[i]);
        for (int i = 0; i < 3; i++) s_beat(b[i]);
        s_err++;
        s_pkt++;
        s_drain(50);
        n_checks++;
        if (s_exp.size() != 0 || s_fill_level !== 32'd0) begin
            n_fail++; $display("FAIL errors_drain: got left=%0d fill=%0d, expected 0 0", s_exp.size(), s_fill_level);
        end
        n_checks++;
        if (s_err_count !== (STATS ? 32'(s_err) : 32'd0) || s_pkt_count !== (STATS ? 32'(s_pkt) : 32'd0)) begin
            n_fail++;
            $display("FAIL errors_counts: got err=%0d pkt=%0d, expected %0d %0d", s_err_count, s_pkt_count, STATS ? s_err : 0, STATS ? s_pkt : 0);
        end
    endtask

    task automatic test_almost_full;
        s_out_ready = 1'b0;
        s_packet(6, 1'b1);
        s_pkt++;
        n_checks++;
        if (s_in_almost_full !== 1'b1 || s_fill_level !== 32'd6) begin
            n_fail++; $display("FAIL af_set: got af=%b fill=%0d, expected 1 6", s_in_almost_full, s_fill_level);
        end
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (s_in_almost_full !== 1'b1 || s_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL af_hold: got af=%b valid=%b, expected 1 1", s_in_almost_full, s_out_valid);
        end
        s_out_ready = 1'b1;
        @(posedge Clk); #1;
        s_out_ready = 1'b0;
        n_checks++;
        if (s_in_almost_full !== 1'b0 || s_fill_level !== 32'd5) begin
            n_fail++; $display("FAIL af_clear: got af=%b fill=%0d, expected 0 5", s_in_almost_full, s_fill_level);
        end
        s_out_ready = 1'b1;
        s_drain(50);
        n_checks++;
        if (s_exp.size() != 0 || s_fill_level !== 32'd0) begin
            n_fail++; $display("FAIL af_drain: got left=%0d fill=%0d, expected 0 0", s_exp.size(), s_fill_level);
        end
    endtask

    task automatic test_exact_fill;
        s_out_ready = 1'b0;
        s_packet(8, 1'b1);
        s_pkt++;
        n_checks++;
        if (s_fill_level !== 32'd8 || s_in_almost_full !== 1'b1) begin
            n_fail++; $display("FAIL full_accept: got fill=%0d af=%b, expected 8 1", s_fill_level, s_in_almost_full);
        end
        s_packet(1, 1'b0);
        s_drop++;
        n_checks++;
        if (s_drop_count !== (STATS ? 32'(s_drop) : 32'd0) || s_fill_level !== 32'd8) begin
            n_fail++; $display("FAIL full_single_drop: got drop=%0d fill=%0d, expected %0d 8", s_drop_count, s_fill_level, STATS ? s_drop : 0);
        end
        @(posedge Clk); #1;
        s_out_ready = 1'b1;
        repeat (8) @(posedge Clk);
        #1;
        n_checks++;
        if (s_exp.size() != 0 || s_fill_level !== 32'd0) begin
            n_fail++; $display("FAIL full_throughput: got left=%0d fill=%0d after 8 cycles, expected 0 0", s_exp.size(), s_fill_level);
        end
    endtask

    task automatic test_back_to_back;
        int lens[6] = '{1, 2, 1, 3, 1, 2};
        s_out_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            s_packet(lens[p], 1'b1);
            s_pkt++;
        end
        s_drain(60);
        n_checks++;
        if (s_exp.size() != 0 || s_fill_level !== 32'd0) begin
            n_fail++; $display("FAIL b2b_drain: got left=%0d fill=%0d, expected 0 0", s_exp.size(), s_fill_level);
        end
        n_checks++;
        if (s_pkt_count !== (STATS ? 32'(s_pkt) : 32'd0)) begin
            n_fail++; $display("FAIL b2b_pkt_count: got %0d, expected %0d", s_pkt_count, STATS ? s_pkt : 0);
        end
    endtask

    task automatic test_reset_mid;
        s_out_ready = 1'b0;
        s_packet(2, 1'b1);
        repeat (2) @(posedge Clk);
        #1;
        s_beat(mk(1'b1, 1'b0, 2'd1, 32'hDEAD_0001));
        s_beat(mk(1'b0, 1'b0, 2'd2, 32'hDEAD_0002));
        #2 Rst_n = 1'b0;
        #1;
        n_checks++;
        if (s_out_valid !== 1'b0 || {s_out_sop, s_out_eop, s_out_empty, s_out_data} !== '0) begin
            n_fail++; $display("FAIL midreset_egress: got valid=%b data=%h, expected 0 0", s_out_valid, s_out_data);
        end
        n_checks++;
        if (s_fill_level !== 32'd0 || s_in_almost_full !== 1'b0 || s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_status: got fill=%0d af=%b rdy=%b, expected 0 0 0", s_fill_level, s_in_almost_full, s_in_ready);
        end
        n_checks++;
        if ({s_pkt_count, s_drop_count, s_err_count} !== 96'd0) begin
            n_fail++; $display("FAIL midreset_counters: got %0d/%0d/%0d, expected 0/0/0", s_pkt_count, s_drop_count, s_err_count);
        end
        s_exp.delete();
        s_pkt = 0; s_drop = 0; s_err = 0;
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk); #1;
        s_out_ready = 1'b1;
        s_packet(3, 1'b1);
        s_pkt++;
        s_drain(50);
        n_checks++;
        if (s_exp.size() != 0 || s_fill_level !== 32'd0 || s_pkt_count !== (STATS ? 32'(s_pkt) : 32'd0)) begin
            n_fail++; $display("FAIL midreset_next: got left=%0d fill=%0d pkt=%0d, expected 0 0 %0d", s_exp.size(), s_fill_level, s_pkt_count, STATS ? s_pkt : 0);
        end
    endtask

    task automatic test_random;
        bit done = 1'b0;
        fork
            begin
                beat_t b;
                int    len;
                for (int p = 0; p < 1000; p++) begin
                    len = $urandom_range(1, 20);
                    for (int w = 0; w < 400 && l_in_almost_full; w++) begin
                        @(posedge Clk); #1;
                    end
                    for (int i = 0; i < len; i++) begin
                        b = mk(i == 0, i == len - 1, EW'($urandom), $urandom);
                        l_exp.push_back(b);
                        l_beat(b);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge Clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge Clk); #1;
                    l_out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        l_out_ready = 1'b1;
        for (int i = 0; i < 3000 && l_exp.size() != 0; i++) @(posedge Clk);
        #1;
        n_checks++;
        if (l_exp.size() != 0 || l_fill_level !== 32'd0) begin
            n_fail++; $display("FAIL random_drain: got left=%0d fill=%0d, expected 0 0", l_exp.size(), l_fill_level);
        end
        n_checks++;
        if (l_pkt_count !== (STATS ? 32'd1000 : 32'd0) || l_drop_count !== 32'd0 || l_err_count !== 32'd0) begin
            n_fail++;
            $display("FAIL random_counts: got pkt=%0d drop=%0d err=%0d, expected %0d 0 0", l_pkt_count, l_drop_count, l_err_count, STATS ? 1000 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_errors();
        test_almost_full();
        test_exact_fill();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
